ps2_device_tx: RTL



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_tx_fifo.sv | 64 ++++++
 rtl/ps2_device_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame constants and parity helper
// for the PS/2 device-side transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIT_HIGH,
        BIT_LOW,
        GAP,
        INHIBIT
    } tx_state_t;

    localparam int FRAME_BITS = 11;
    localparam int GAP_HALVES = 2;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: DEPTH x 8 synchronous FIFO with registered full/empty
// flags and a head peek; the byte stays at the head until popped.
module ps2_tx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rp];

    always_comb begin
        cnt_n = cnt;
        if (push_ok && !pop_ok)
            cnt_n = cnt + CW'(1);
        else if (pop_ok && !push_ok)
            cnt_n = cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push_ok)
                wp <= wp + AW'(1);
            if (pop_ok)
                rp <= rp + AW'(1);
            cnt   <= cnt_n;
            full  <= (cnt_n == CW'(DEPTH));
            empty <= (cnt_n == CW'(0));
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 keyboard-side transmitter with FIFO, bus-inhibit
// back-off and retransmit. Optional PS2_TX_PARITY_INJ_EN adds inj_parity.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int PS2_HZ = 12_500,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       busy,
    output logic       frame_done,
`ifdef PS2_TX_PARITY_INJ_EN
    input  logic       inj_parity,
`endif
    output logic       aborted
);

    localparam int HALF = CLK_HZ / (2 * PS2_HZ);
    localparam int PW   = $clog2(2 * HALF);

    localparam logic [PW-1:0] PH_HALF_END  = PW'(HALF - 1);
    localparam logic [PW-1:0] PH_GAP_END   = PW'(GAP_HALVES * HALF - 2);
    localparam logic [PW-1:0] PH_QUIET_END = PW'(GAP_HALVES * HALF - 1);
    localparam logic [3:0]    LAST_BIT     = 4'(FRAME_BITS - 1);

    tx_state_t     state;
    logic [PW-1:0] ph;
    logic [3:0]    idx;
    logic [9:0]    sh;
    logic          clk_s1;
    logic          clk_s2;
    logic          drv_d1;
    logic          drv_d2;
    logic          head_ok_q;
    logic          par_flip;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          inhibit;
    logic          phase_end;

`ifdef PS2_TX_PARITY_INJ_EN
    assign par_flip = inj_parity;
`else
    assign par_flip = 1'b0;
`endif

    ps2_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign in_ready  = ~full;
    assign busy      = (state == BIT_HIGH) || (state == BIT_LOW) ||
                       (state == GAP) || ~empty;
    assign phase_end = (ph == PH_HALF_END);
    assign pop       = (state == BIT_LOW) && phase_end && (idx == LAST_BIT);

    // Drive history is delayed to match the synchronizer, so our own
    // rising edge is not mistaken for a host holding the clock low.
    assign inhibit = ~clk_s2 & ps2_clk_out & drv_d2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            drv_d1    <= 1'b1;
            drv_d2    <= 1'b1;
            head_ok_q <= 1'b0;
        end else begin
            clk_s1    <= ps2_clk_in;
            clk_s2    <= clk_s1;
            drv_d1    <= ps2_clk_out;
            drv_d2    <= drv_d1;
            head_ok_q <= ~empty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ph           <= '0;
            idx          <= '0;
            sh           <= '1;
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
            frame_done   <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            aborted    <= 1'b0;
            unique case (state)
                IDLE: begin
                    ph <= '0;
                    if (inhibit) begin
                        state <= INHIBIT;
                    end else if (head_ok_q) begin
                        sh           <= {1'b1, odd_parity(head) ^ par_flip, head};
                        idx          <= '0;
                        ps2_clk_out  <= 1'b1;
                        ps2_data_out <= 1'b0;
                        state        <= BIT_HIGH;
                    end
                end
                BIT_HIGH: begin
                    if (inhibit && idx != LAST_BIT) begin
                        aborted      <= 1'b1;
                        ps2_clk_out  <= 1'b1;
                        ps2_data_out <= 1'b1;
                        ph           <= '0;
                        state        <= INHIBIT;
                    end else if (phase_end) begin
                        ph          <= '0;
                        ps2_clk_out <= 1'b0;
                        state       <= BIT_LOW;
                    end else begin
                        ph <= ph + PW'(1);
                    end
                end
                BIT_LOW: begin
                    if (phase_end) begin
                        ph          <= '0;
                        ps2_clk_out <= 1'b1;
                        if (idx == LAST_BIT) begin
                            frame_done   <= 1'b1;
                            ps2_data_out <= 1'b1;
                            state        <= GAP;
                        end else begin
                            idx          <= idx + 4'd1;
                            ps2_data_out <= sh[0];
                            sh           <= {1'b1, sh[9:1]};
                            state        <= BIT_HIGH;
                        end
                    end else begin
                        ph <= ph + PW'(1);
                    end
                end
                GAP: begin
                    // The IDLE cycle supplies the last released cycle.
                    if (inhibit) begin
                        ph    <= '0;
                        state <= INHIBIT;
                    end else if (ph == PH_GAP_END) begin
                        ph    <= '0;
                        state <= IDLE;
                    end else begin
                        ph <= ph + PW'(1);
                    end
                end
                INHIBIT: begin
                    if (!clk_s2) begin
                        ph <= '0;
                    end else if (ph == PH_QUIET_END) begin
                        ph    <= '0;
                        state <= IDLE;
                    end else begin
                        ph <= ph + PW'(1);
                    end
                end
                default: begin
                    ph    <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
